vn_debias_packer: RTL and testbench
===================================

Name: vn_debias_packer

Overview:
- Multi-channel von Neumann de-biaser with word packing and output buffering.
- Takes NUM_CH raw TRNG bit streams. Each channel is de-biased by pairwise von Neumann extraction, or passed through raw in bypass mode.
- Surviving bits are packed LSB-first into WORD_W-bit words. Words are buffered in a FIFO_DEPTH-entry FIFO with a valid/ready output handshake.
- Sits between the ring-oscillator sampling stage and the random-number consumer.

Parameters:
- NUM_CH, 4: number of independent raw bit channels.
- WORD_W, 32: output word width in bits; must be >= NUM_CH.
- FIFO_DEPTH, 4: output FIFO depth in words; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  sample strobe; rnd is consumed only on cycles with enable=1.
- bypass  in  1  0 = von Neumann mode, 1 = raw pass-through mode.
- rnd  in  NUM_CH  raw random bits, one per channel.
- out_data  out  WORD_W  packed random word, head of the FIFO.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (one clk edge with rst=1): pair phase=0, first-bit regs=0, accumulator=0, bit count=0, FIFO empty. out_valid=0, out_data=0, fifo_level=0, overflow=0. Reset mid-word discards the partial word and all FIFO contents.
- Pair phase: one shared phase bit. It toggles only on enable=1 cycles while bypass=0; enable=0 holds it, so a pair may straddle idle cycles.
  - Phase 0 + enable: capture rnd[i] into first[i] for all i.
  - Phase 1 + enable: per channel, if first[i] != rnd[i], emit first[i] (10 -> 1, 01 -> 0); if equal (00, 11), emit nothing.
- Bypass (bypass=1): every enable cycle emits all NUM_CH bits of rnd.
- Mode change: any cycle where bypass differs from its registered previous value forces phase=0. The accumulator is kept.
- Packing order: emitted bits of one cycle are appended in ascending channel index. The first bit in a word lands at bit 0.
- Accumulator: WORD_W+NUM_CH bits wide. Count increases by 0..NUM_CH per cycle.
- Word completion: when count+new >= WORD_W, the low WORD_W bits form a word.
  - The remaining count+new-WORD_W bits shift down to bit 0 and count becomes the remainder, in the same cycle.
  - The word is written to the FIFO at that clock edge.
- Latency: word completing at edge t into an empty FIFO gives out_valid=1 and out_data=word after edge t.
- FIFO is first-word-fall-through:
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop when full is allowed; the push succeeds and the level is unchanged.
  - Push when full without pop: the word is dropped, overflow set to 1 (sticky until rst), level stays FIFO_DEPTH. The accumulator continues normally.
- fifo_level: registered, updated the same edge as push/pop. Pointers wrap modulo FIFO_DEPTH.
- out_data must be stable while out_valid=1 and out_ready=0.

Test Plan:
1. NUM_CH=1, WORD_W=8, bypass=0, enable=1 always; rnd pairs 10 repeated 8 times -> one word 0xFF, out_valid rises one cycle after the 16th sample. Pairs 01 x8 -> 0x00.
2. NUM_CH=1, WORD_W=8; pairs 10,01 alternating x4 interleaved with pairs 00 and 11 -> single word 0x55; the 00/11 pairs add nothing (count unchanged).
3. NUM_CH=4, WORD_W=8, bypass=1; rnd=4'b1010 for 2 enable cycles -> word 0xAA. enable low for 5 cycles between them -> same 0xAA, with no extra word.
4. NUM_CH=4, WORD_W=6, bypass=1; rnd=4'hF for 3 cycles -> word 0x3F after cycle 2, count=0 after cycle 3... wait: 12 bits = two words 0x3F, 0x3F. Check carry-over: 4 bits, then 8 -> first word plus remainder 2, then 6 -> second word.
5. FIFO_DEPTH=4, out_ready=0; complete 5 words -> fifo_level=4, overflow=1, words 1-4 read back in order once out_ready=1. Push and pop in the same cycle while full -> level stays 4 and overflow is not set.
6. Assert rst with count=5 and 2 words queued, then 8 more pairs of 10 -> out_valid=0 right after reset, then exactly one word 0xFF. Toggling bypass mid-pair -> phase restarts and the stale first bit is never emitted.

Source files
------------

// File: rtl/vn_debias_packer.sv
// Multi-channel von Neumann de-biaser that packs surviving bits LSB-first into
// words and buffers them in a small first-word-fall-through FIFO.
module vn_debias_packer #(
  parameter int NUM_CH     = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          bypass,
  input  logic [NUM_CH-1:0]             rnd,
  output logic [WORD_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int ACC_W = WORD_W + NUM_CH;
  localparam int CW    = $clog2(ACC_W + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;

  logic              phase_reg, phase_next;
  logic              bypass_prev_reg;
  logic [NUM_CH-1:0] first_reg;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [CW-1:0]     cnt_reg, cnt_next;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic              overflow_reg;

  logic              mode_change, eff_phase;
  logic [NUM_CH-1:0] emit_v, emit_b;
  logic [ACC_W-1:0]  packed_bits, combined;
  logic [CW-1:0]     new_cnt, sum;
  logic              word_done;
  logic [WORD_W-1:0] word;
  logic              full, pop, do_push;

  // A bypass edge restarts pairing so a half-captured pair is never completed.
  assign mode_change = bypass ^ bypass_prev_reg;
  assign eff_phase   = phase_reg & ~mode_change;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign emit_v[gi] = enable & (bypass | (eff_phase & (first_reg[gi] ^ rnd[gi])));
    assign emit_b[gi] = bypass ? rnd[gi] : first_reg[gi];
  end

  always_comb begin
    phase_next = eff_phase;
    if (enable && !bypass)
      phase_next = ~eff_phase;
  end

  // Compact this cycle's surviving bits in ascending channel order.
  always_comb begin
    new_cnt     = '0;
    packed_bits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (emit_v[i]) begin
        packed_bits = packed_bits | (ACC_W'(emit_b[i]) << new_cnt);
        new_cnt     = new_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    combined  = acc_reg | (packed_bits << cnt_reg);
    sum       = cnt_reg + new_cnt;
    word_done = (sum >= CW'(WORD_W));
    word      = combined[WORD_W-1:0];
    acc_next  = combined;
    cnt_next  = sum;
    if (word_done) begin
      acc_next = combined >> WORD_W;
      cnt_next = sum - CW'(WORD_W);
    end
  end

  assign full    = (level_reg == LW'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign do_push = word_done & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg       <= 1'b0;
      bypass_prev_reg <= 1'b0;
      first_reg       <= '0;
      acc_reg         <= '0;
      cnt_reg         <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      phase_reg       <= phase_next;
      bypass_prev_reg <= bypass;
      if (enable && !bypass && !eff_phase)
        first_reg <= rnd;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      level_reg <= level_reg + LW'(do_push) - LW'(pop);
      if (word_done && full && !pop)
        overflow_reg <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wr_ptr_reg] <= word;
  end

  assign out_valid  = (level_reg != '0);
  assign out_data   = out_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_vn_debias_packer.sv
// Directed bench for vn_debias_packer (4 channels, 8-bit words, 4-deep FIFO);
// single-channel cases drive channel 0 only and hold the others at 0.
module tb_vn_debias_packer;

  logic       clk = 1'b0;
  logic       rst, enable, bypass, out_ready;
  logic [3:0] rnd;
  logic [7:0] out_data;
  logic       out_valid, overflow;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;

  vn_debias_packer #(.NUM_CH(4), .WORD_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bypass(bypass), .rnd(rnd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic byp, input logic [3:0] r, input logic rdy);
    enable = en; bypass = byp; rnd = r; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic pair0(input logic a, input logic b);
    step(1'b1, 1'b0, {3'b000, a}, 1'b0);
    step(1'b1, 1'b0, {3'b000, b}, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    $display("pop %s: data=0x%02h level=%0d", tag, out_data, fifo_level);
    step(1'b0, bypass, 4'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; bypass = 1'b0; rnd = 4'h0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Pairs 10 x8 -> 0xFF, word appears right after the 16th sample
    for (int i = 0; i < 7; i++) pair0(1'b1, 1'b0);
    step(1'b1, 1'b0, 4'h1, 1'b0);
    check("t1_pre_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    check("t1_level", 32'(fifo_level), 32'd1);
    pop_check("t1_ff", 8'hFF);
    for (int i = 0; i < 8; i++) pair0(1'b0, 1'b1);
    check("t1b_level", 32'(fifo_level), 32'd1);
    pop_check("t1_00", 8'h00);
    check("t1_empty", 32'(out_valid), 32'd0);

    // 10/01 alternating, 00/11 pairs contribute nothing -> 0x55
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pair0(1'b1, 1'b0);
      pair0(1'b0, 1'b0);
      pair0(1'b0, 1'b1);
      pair0(1'b1, 1'b1);
    end
    check("t2_level", 32'(fifo_level), 32'd1);
    pop_check("t2_55", 8'h55);

    // Bypass, enable gaps do not add bits -> one 0xAA
    do_reset();
    step(1'b1, 1'b1, 4'hA, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h5, 1'b0);
    check("t3_gap_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 4'hA, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'h0, 1'b0);
    check("t3_level", 32'(fifo_level), 32'd1);
    pop_check("t3_aa", 8'hAA);

    // Carry-over: 2 VN bits, then 4-bit bypass samples straddle word edges
    do_reset();
    step(1'b1, 1'b0, 4'b0001, 1'b0);
    step(1'b1, 1'b0, 4'b0010, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'b0110, 1'b0);
    step(1'b1, 1'b1, 4'b0011, 1'b0);
    step(1'b1, 1'b1, 4'b1100, 1'b0);
    check("t4_level", 32'(fifo_level), 32'd2);
    pop_check("t4_w0", 8'hBD);
    pop_check("t4_w1", 8'h0D);

    // FIFO full, push+pop while full, then overflow drop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 4'(2*k+1), 1'b0);
      step(1'b1, 1'b1, 4'(2*k+2), 1'b0);
    end
    check("t5_full_level", 32'(fifo_level), 32'd4);
    check("t5_full_ovf", 32'(overflow), 32'd0);
    check("t5_head", 32'(out_data), 32'h21);
    step(1'b1, 1'b1, 4'h9, 1'b0);
    check("t5_hold_head", 32'(out_data), 32'h21);
    step(1'b1, 1'b1, 4'hA, 1'b1);
    check("t5_pp_level", 32'(fifo_level), 32'd4);
    check("t5_pp_ovf", 32'(overflow), 32'd0);
    step(1'b1, 1'b1, 4'hB, 1'b0);
    step(1'b1, 1'b1, 4'hC, 1'b0);
    check("t5_ovf_level", 32'(fifo_level), 32'd4);
    check("t5_ovf", 32'(overflow), 32'd1);
    pop_check("t5_r0", 8'h43);
    pop_check("t5_r1", 8'h65);
    pop_check("t5_r2", 8'h87);
    pop_check("t5_r3", 8'hA9);
    check("t5_drained", 32'(out_valid), 32'd0);
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-word with words queued discards everything
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'hF, 1'b0);
    step(1'b1, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    pair0(1'b1, 1'b0);
    check("t6_pre_level", 32'(fifo_level), 32'd2);
    do_reset();
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pair0(1'b1, 1'b0);
    check("t6_level", 32'(fifo_level), 32'd1);
    pop_check("t6_ff", 8'hFF);
    for (int i = 0; i < 3; i++) pair0(1'b1, 1'b0);
    check("t6_no_extra", 32'(fifo_level), 32'd0);

    // Bypass toggle mid-pair drops the stale first bit
    do_reset();
    step(1'b1, 1'b0, 4'h1, 1'b0);
    step(1'b0, 1'b1, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    pair0(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pair0(1'b1, 1'b0);
      pair0(1'b0, 1'b1);
    end
    check("t7_level", 32'(fifo_level), 32'd1);
    pop_check("t7_55", 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
